// File: rtl/regbank_pkg.sv
// Shared definitions for the 8-entry register bank write side: default widths,
// register count, clear-sequence bound and the FSM state encoding.
package regbank_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_SEL_W  = 3;
    localparam int NREGS      = 2 ** DEF_SEL_W;
    localparam int CLR_LAST   = NREGS - 1;

    // Plain localparam encoding keeps the state vector compatible with older tools.
    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE  = 1'b0;
    localparam state_t ST_CLEAR = 1'b1;

endpackage : regbank_pkg

// File: rtl/dec_onehot.sv
// One-hot decoder with enable: drives exactly one bit of onehot when en is high,
// all zeros otherwise. Produces the per-register write enables.
module dec_onehot
    import regbank_pkg::*;
#(
    parameter int SEL_W = DEF_SEL_W,
    parameter int NOUT  = 2 ** SEL_W
) (
    input  logic             en,
    input  logic [SEL_W-1:0] sel,
    output logic [NOUT-1:0]  onehot
);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule : dec_onehot

// File: rtl/demux8_regbank.sv
// Write side of the 8-entry register bank: valid/ready write port, one-hot routed
// writes and an 8-cycle bank clear. Define ZERO_REG_EN to hard-wire r0 to zero.
module demux8_regbank
    import regbank_pkg::*;
#(
    parameter int                 DATA_W    = DEF_DATA_W,
    parameter int                 SEL_W     = DEF_SEL_W,
    parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [SEL_W-1:0]  wr_sel,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic [DATA_W-1:0] r0,
    output logic [DATA_W-1:0] r1,
    output logic [DATA_W-1:0] r2,
    output logic [DATA_W-1:0] r3,
    output logic [DATA_W-1:0] r4,
    output logic [DATA_W-1:0] r5,
    output logic [DATA_W-1:0] r6,
    output logic [DATA_W-1:0] r7
);

    localparam int               NR       = 2 ** SEL_W;
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(CLR_LAST);
`ifdef ZERO_REG_EN
    localparam bit ZERO_R0 = 1'b1;
`else
    localparam bit ZERO_R0 = 1'b0;
`endif

    state_t              state;
    logic [SEL_W-1:0]    clr_idx;
    logic                in_clear;
    logic                wr_fire;
    logic                dec_en;
    logic [SEL_W-1:0]    dec_sel;
    logic [DATA_W-1:0]   dec_data;
    logic [NR-1:0]       we;
    logic [DATA_W-1:0]   regs [NR];

    assign in_clear = (state == ST_CLEAR);
    assign clr_busy = in_clear;
    // A pending clear request blocks the write in the same cycle: clear wins.
    assign wr_ready = !rst && (state == ST_IDLE) && !clr_req;
    assign wr_fire  = wr_valid && wr_ready;

    // The clear sequence borrows the write path: index from the counter, data forced to 0.
    assign dec_en   = wr_fire || in_clear;
    assign dec_sel  = in_clear ? clr_idx : wr_sel;
    assign dec_data = in_clear ? '0 : wr_data;

    dec_onehot #(
        .SEL_W (SEL_W),
        .NOUT  (NR)
    ) u_dec (
        .en     (dec_en),
        .sel    (dec_sel),
        .onehot (we)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            clr_idx <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clr_req) begin
                        state <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    clr_idx <= clr_idx + 1'b1;
                    if (clr_idx == LAST_IDX) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: the bank is flops, not RAM, so every entry is reset explicitly to a known value.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (ZERO_R0 && i == 0) begin
                regs[i] <= '0;
            end else if (rst) begin
                regs[i] <= RESET_VAL;
            end else if (we[i]) begin
                regs[i] <= dec_data;
            end
        end
    end

    assign r0 = regs[0];
    assign r1 = regs[1];
    assign r2 = regs[2];
    assign r3 = regs[3];
    assign r4 = regs[4];
    assign r5 = regs[5];
    assign r6 = regs[6];
    assign r7 = regs[7];

endmodule : demux8_regbank

// File: tb/tb_demux8_regbank.sv
// Directed self-checking bench for demux8_regbank: reset, writes, clear collisions,
// reset mid-clear, backpressure, clear-request handling and the r0 write.
module tb_demux8_regbank;

    localparam logic [7:0] RV = 8'hA5;
`ifdef ZERO_REG_EN
    localparam logic [7:0] R0_RST = 8'h00;
    localparam logic [7:0] R0_W77 = 8'h00;
`else
    localparam logic [7:0] R0_RST = 8'hA5;
    localparam logic [7:0] R0_W77 = 8'h77;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_valid;
    logic       wr_ready;
    logic [2:0] wr_sel;
    logic [7:0] wr_data;
    logic       clr_req;
    logic       clr_busy;
    logic [7:0] r [8];
    logic [7:0] exp_r [8];

    int errors = 0;
    int checks = 0;
    int cnt;

    always #5 clk = ~clk;

    demux8_regbank #(
        .DATA_W    (8),
        .SEL_W     (3),
        .RESET_VAL (RV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_sel   (wr_sel),
        .wr_data  (wr_data),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .r0       (r[0]),
        .r1       (r[1]),
        .r2       (r[2]),
        .r3       (r[3]),
        .r4       (r[4]),
        .r5       (r[5]),
        .r6       (r[6]),
        .r7       (r[7])
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s r%0d", tag, i), r[i], exp_r[i]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input logic [7:0] v);
        for (int i = 0; i < 8; i++) exp_r[i] = v;
    endtask

    initial begin
        rst = 1'b1; wr_valid = 1'b0; wr_sel = '0; wr_data = '0; clr_req = 1'b0;

        // 1. reset
        tick(); tick();
        set_all(RV); exp_r[0] = R0_RST;
        check_all("reset");
        check("ready_in_rst", {7'b0, wr_ready}, 8'd0);
        check("busy_in_rst", {7'b0, clr_busy}, 8'd0);
        rst = 1'b0; #1;
        check("ready_after_rst", {7'b0, wr_ready}, 8'd1);

        // 2. single write, no bypass
        wr_sel = 3'd5; wr_data = 8'h3C; wr_valid = 1'b1; #1;
        check("wr_ready_idle", {7'b0, wr_ready}, 8'd1);
        check("no_bypass", r[5], 8'hA5);
        tick();
        wr_valid = 1'b0;
        exp_r[5] = 8'h3C;
        check_all("write5");

        // 3. clear/write collision
        clr_req = 1'b1; wr_valid = 1'b1; wr_sel = 3'd2; wr_data = 8'hFF; #1;
        check("collide_ready", {7'b0, wr_ready}, 8'd0);
        tick();
        clr_req = 1'b0; wr_valid = 1'b0;
        cnt = 0;
        while (clr_busy && cnt < 20) begin
            cnt++;
            check("clear_ready_low", {7'b0, wr_ready}, 8'd0);
            assert (r[2] !== 8'hFF) else begin
                errors++;
                $error("FAIL collide_r2: observed=%0h expected=not ff", r[2]);
            end
            checks++;
            tick();
        end
        check("clear_len", 8'(cnt), 8'd8);
        set_all(8'h00);
        check_all("after_clear");
        check("ready_after_clear", {7'b0, wr_ready}, 8'd1);

        // 4. reset on the 4th clear cycle
        wr_sel = 3'd1; wr_data = 8'h11; wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        check("write1", r[1], 8'h11);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        tick(); tick(); tick();
        check("midclear_busy", {7'b0, clr_busy}, 8'd1);
        check("midclear_r1", r[1], 8'h00);
        rst = 1'b1;
        tick();
        set_all(RV); exp_r[0] = R0_RST;
        check_all("rst_midclear");
        check("rst_midclear_busy", {7'b0, clr_busy}, 8'd0);
        rst = 1'b0; #1;
        check("rst_midclear_idle", {7'b0, wr_ready}, 8'd1);

        // 5. write held off during clear
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        wr_sel = 3'd6; wr_data = 8'h5A; wr_valid = 1'b1;
        cnt = 0;
        while (clr_busy && cnt < 20) begin
            cnt++;
            tick();
        end
        check("bp_clear_len", 8'(cnt), 8'd8);
        check("bp_ready_idle", {7'b0, wr_ready}, 8'd1);
        check("bp_r6_before", r[6], 8'h00);
        tick();
        wr_valid = 1'b0;
        set_all(8'h00); exp_r[6] = 8'h5A;
        check_all("bp_after");

        // 7. clr_req held: no extension, restarts after return to idle
        clr_req = 1'b1;
        tick();
        cnt = 0;
        while (clr_busy && cnt < 20) begin
            cnt++;
            tick();
        end
        check("hold_clear_len", 8'(cnt), 8'd8);
        check("hold_idle_ready", {7'b0, wr_ready}, 8'd0);
        tick();
        check("hold_restart", {7'b0, clr_busy}, 8'd1);
        clr_req = 1'b0;
        cnt = 0;
        while (clr_busy && cnt < 20) begin
            cnt++;
            tick();
        end
        check("restart_len", 8'(cnt), 8'd8);

        // 6. write to r0
        wr_sel = 3'd0; wr_data = 8'h77; wr_valid = 1'b1; #1;
        check("r0_ready", {7'b0, wr_ready}, 8'd1);
        tick();
        wr_valid = 1'b0;
        set_all(8'h00); exp_r[0] = R0_W77;
        check_all("write0");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_demux8_regbank
